// File: rtl/mem_bus_pkg.sv
//==============================================================================
// Module      : mem_bus_pkg
// Description : Shared size codes, fault codes and FSM state type for the
//               memory bus controller.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package mem_bus_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] FC_NONE       = 2'b00;
    localparam logic [1:0] FC_MISALIGNED = 2'b01;
    localparam logic [1:0] FC_BUS_ERR    = 2'b10;
    localparam logic [1:0] FC_TIMEOUT    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
//==============================================================================
// Module      : mem_lane_align
// Description : Byte-lane steering: byte enables, store replication,
//               alignment check and load extraction with sign/zero extension.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_lane_align
    import mem_bus_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            addr_lo,
    input  logic [1:0]            size,
    input  logic                  unsigned_ld,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata_raw,
    output logic [3:0]            be,
    output logic [DATA_WIDTH-1:0] wdata_rep,
    output logic                  misaligned,
    output logic [DATA_WIDTH-1:0] rdata_ext
);

    logic [DATA_WIDTH-1:0] w_byte_sh;
    logic [DATA_WIDTH-1:0] w_half_sh;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;

    assign w_byte_sh = rdata_raw >> {addr_lo, 3'b000};
    assign w_half_sh = rdata_raw >> {addr_lo[1], 4'b0000};
    assign w_byte    = w_byte_sh[7:0];
    assign w_half    = w_half_sh[15:0];

    always_comb begin
        be         = 4'b0000;
        wdata_rep  = '0;
        misaligned = 1'b0;
        rdata_ext  = '0;
        case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = unsigned_ld ? {{(DATA_WIDTH-8){1'b0}}, w_byte}
                                        : {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                misaligned = addr_lo[0];
                be         = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep  = {2{wdata[15:0]}};
                rdata_ext  = unsigned_ld ? {{(DATA_WIDTH-16){1'b0}}, w_half}
                                         : {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            end
            SZ_WORD: begin
                misaligned = |addr_lo;
                be         = 4'b1111;
                wdata_rep  = wdata;
                rdata_ext  = rdata_raw;
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_bus_controller.sv
//==============================================================================
// Module      : mem_bus_controller
// Description : Runs one load/store on a valid/ready memory bus with alignment
//               checking, bus-error capture and a wait-state timeout.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_bus_controller
    import mem_bus_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [1:0]            size,
    input  logic                  unsigned_ld,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] wdata_in,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    output logic                  mem_we,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_err,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  fault,
    output logic [1:0]            fault_cause
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]            mem_be_q, mem_be_d;
    logic                  mem_we_q, mem_we_d;
    logic [1:0]            addr_lo_q, addr_lo_d;
    logic [1:0]            size_q, size_d;
    logic                  unsigned_q, unsigned_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  fault_q, fault_d;
    logic [1:0]            fault_cause_q, fault_cause_d;

    logic [1:0]            w_lane_addr;
    logic [1:0]            w_lane_size;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata_rep;
    logic                  w_misaligned;
    logic [DATA_WIDTH-1:0] w_rdata_ext;

    // The lane unit checks the incoming request in IDLE and extracts the
    // returning load data from the latched request while in ACCESS.
    assign w_lane_addr = (state_q == ST_IDLE) ? addr_in[1:0] : addr_lo_q;
    assign w_lane_size = (state_q == ST_IDLE) ? size         : size_q;

    mem_lane_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
        .addr_lo     (w_lane_addr),
        .size        (w_lane_size),
        .unsigned_ld (unsigned_q),
        .wdata       (wdata_in),
        .rdata_raw   (mem_rdata),
        .be          (w_be),
        .wdata_rep   (w_wdata_rep),
        .misaligned  (w_misaligned),
        .rdata_ext   (w_rdata_ext)
    );

    always_comb begin
        state_d       = state_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_be_d      = mem_be_q;
        mem_we_d      = mem_we_q;
        addr_lo_d     = addr_lo_q;
        size_d        = size_q;
        unsigned_d    = unsigned_q;
        cnt_d         = cnt_q;
        rdata_d       = rdata_q;
        fault_d       = fault_q;
        fault_cause_d = fault_cause_q;
        case (state_q)
            ST_IDLE: begin
                if (req_write || req_read) begin
                    addr_lo_d  = addr_in[1:0];
                    size_d     = size;
                    unsigned_d = unsigned_ld;
                    if (w_misaligned) begin
                        fault_d       = 1'b1;
                        fault_cause_d = FC_MISALIGNED;
                        state_d       = ST_RESP;
                    end else begin
                        mem_addr_d  = {addr_in[ADDR_WIDTH-1:2], 2'b00};
                        mem_be_d    = w_be;
                        mem_wdata_d = w_wdata_rep;
                        mem_we_d    = req_write;
                        cnt_d       = '0;
                        state_d     = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (mem_ready) begin
                    state_d = ST_RESP;
                    if (mem_err) begin
                        fault_d       = 1'b1;
                        fault_cause_d = FC_BUS_ERR;
                    end else if (!mem_we_q) begin
                        rdata_d = w_rdata_ext;
                    end
                end else if ((TIMEOUT_CYCLES != 0) &&
                             (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
                    state_d       = ST_RESP;
                    fault_d       = 1'b1;
                    fault_cause_d = FC_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d       = ST_IDLE;
                fault_d       = 1'b0;
                fault_cause_d = FC_NONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_be_q      <= '0;
            mem_we_q      <= 1'b0;
            addr_lo_q     <= '0;
            size_q        <= '0;
            unsigned_q    <= 1'b0;
            cnt_q         <= '0;
            rdata_q       <= '0;
            fault_q       <= 1'b0;
            fault_cause_q <= FC_NONE;
        end else begin
            state_q       <= state_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_be_q      <= mem_be_d;
            mem_we_q      <= mem_we_d;
            addr_lo_q     <= addr_lo_d;
            size_q        <= size_d;
            unsigned_q    <= unsigned_d;
            cnt_q         <= cnt_d;
            rdata_q       <= rdata_d;
            fault_q       <= fault_d;
            fault_cause_q <= fault_cause_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_be      = mem_be_q;
    assign mem_we      = mem_we_q;
    assign mem_valid   = (state_q == ST_ACCESS);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_RESP);
    assign rdata       = rdata_q;
    assign fault       = fault_q;
    assign fault_cause = fault_cause_q;

endmodule

`default_nettype wire
